// File: rtl/seg7_pkg.sv
// seg7_pkg: digit width, blank pattern and nibble to active-low {a..g} segment encoding
package seg7_pkg;
  localparam int DW = 4;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  function automatic logic [6:0] seg_encode(input logic [DW-1:0] n);
    return SEG_LUT[n];
  endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: divide-by-PRESCALE tick (clk, rst active-low async, enable freezes phase, clear restarts, tick high on last count)
module tick_gen #(
  parameter int PRESCALE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  logic [CW-1:0] cnt;
  assign tick = enable && cnt == LAST;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= clear || tick ? '0 : enable ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/bcd_counter_mux7seg.sv
// bcd_counter_mux7seg: N-digit BCD/hex up/down counter with prescaler, load, carry pulse and muxed active-low 7-seg (seg7, an) driver
module bcd_counter_mux7seg
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10,
  parameter int SCAN_DIV = 4,
  parameter int BCD      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 upDown,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_value,
  output logic [DIGITS*DW-1:0] count,
  output logic                 carry,
  output logic [6:0]           seg7,
  output logic [DIGITS-1:0]    an
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] DMAX = BCD != 0 ? 4'd9 : 4'd15;
  logic tick, scan_tick, wrap;
  logic [DIGITS*DW-1:0] step, clamped;
  logic [IW-1:0] idx;
  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk, .rst, .enable, .clear(load), .tick
  );
  tick_gen #(.PRESCALE(SCAN_DIV)) u_scan (
    .clk, .rst, .enable(1'b1), .clear(1'b0), .tick(scan_tick)
  );
  // ripple the +/-1 through the digits; wrap stays set only while every lower digit was at its end value
  always_comb begin
    wrap = 1'b1;
    step = count;
    clamped = load_value;
    for (int i = 0; i < DIGITS; i++) begin
      logic [DW-1:0] d, l;
      d = count[i*DW +: DW];
      l = load_value[i*DW +: DW];
      step[i*DW +: DW] = !wrap ? d : upDown ? (d == DMAX ? '0 : d + 1'b1) : (d == '0 ? DMAX : d - 1'b1);
      wrap = wrap && d == (upDown ? DMAX : '0);
      clamped[i*DW +: DW] = BCD != 0 && l > 4'd9 ? 4'd9 : l;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      carry <= 1'b0;
      idx   <= '0;
      an    <= ~DIGITS'(1);
      seg7  <= seg_encode('0);
    end else begin
      count <= load ? clamped : tick ? step : count;
      carry <= !load && tick && wrap;
      idx   <= !scan_tick ? idx : idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      an    <= ~(DIGITS'(1) << idx);
      seg7  <= seg_encode(count[{idx, 2'b00} +: DW]);
    end
endmodule

// File: tb/tb_bcd_counter_mux7seg.sv
// tb_bcd_counter_mux7seg: two configurations checked every cycle against an integer-arithmetic model plus literal checkpoints
module tb_bcd_counter_mux7seg;
  logic clk = 0, rst = 1, enable = 0, up_down = 1, load = 0;
  logic [15:0] load_value = '0;
  logic [7:0] count_a;
  logic [15:0] count_b;
  logic carry_a, carry_b;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a;
  logic [3:0] an_b;
  int checks = 0, errors = 0;
  bit chk_on = 0;

  localparam int ND [2] = '{2, 4};
  localparam int PS [2] = '{10, 3};
  localparam int SD [2] = '{1, 3};
  localparam int RX [2] = '{10, 16};
  localparam logic [3:0] MASK [2] = '{4'h3, 4'hF};
  logic [6:0] lut [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  bcd_counter_mux7seg #(.DIGITS(2), .PRESCALE(10), .SCAN_DIV(1), .BCD(1)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .upDown(up_down), .load(load),
    .load_value(load_value[7:0]), .count(count_a), .carry(carry_a), .seg7(seg_a), .an(an_a)
  );
  bcd_counter_mux7seg #(.DIGITS(4), .PRESCALE(3), .SCAN_DIV(3), .BCD(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .upDown(up_down), .load(load),
    .load_value(load_value), .count(count_b), .carry(carry_b), .seg7(seg_b), .an(an_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[dut%0d] t=%0t actual=%h required=%h", nm, m, $time, act, exp);
    end
  endtask

  // model: count held as a plain integer in radix RX, digits derived by division
  int val [2], pre [2], sc [2], idx [2];
  bit cy [2];
  logic [6:0] eseg [2];
  logic [3:0] ean [2];

  function automatic logic [15:0] to_vec(input int v, input int m);
    logic [15:0] r = '0;
    for (int i = 0; i < ND[m]; i++) r[4*i +: 4] = 4'((v / RX[m] ** i) % RX[m]);
    return r;
  endfunction

  function automatic int load_int(input int m);
    int acc = 0;
    for (int i = 0; i < ND[m]; i++) begin
      int d;
      d = int'(load_value[4*i +: 4]);
      if (RX[m] == 10 && d > 9) d = 9;
      acc += d * RX[m] ** i;
    end
    return acc;
  endfunction

  always @(posedge clk or negedge rst)
    for (int m = 0; m < 2; m++) begin
      int md;
      md = RX[m] ** ND[m];
      if (!rst) begin
        val[m] = 0; pre[m] = 0; sc[m] = 0; idx[m] = 0; cy[m] = 0;
        eseg[m] = 7'b0000001;
        ean[m] = 4'hE & MASK[m];
      end else begin
        eseg[m] = lut[(val[m] / RX[m] ** idx[m]) % RX[m]];
        ean[m] = ~(4'd1 << idx[m]) & MASK[m];
        if (sc[m] == SD[m] - 1) begin
          sc[m] = 0;
          idx[m] = (idx[m] + 1) % ND[m];
        end else sc[m]++;
        if (load) begin
          val[m] = load_int(m); pre[m] = 0; cy[m] = 0;
        end else if (enable && pre[m] == PS[m] - 1) begin
          pre[m] = 0;
          cy[m] = up_down ? val[m] == md - 1 : val[m] == 0;
          val[m] = up_down ? (val[m] + 1) % md : (val[m] + md - 1) % md;
        end else begin
          cy[m] = 0;
          if (enable) pre[m]++;
        end
      end
    end

  always @(negedge clk)
    if (chk_on)
      for (int m = 0; m < 2; m++) begin
        chk("count", m, m == 0 ? {24'h0, count_a} : {16'h0, count_b}, {16'h0, to_vec(val[m], m)});
        chk("carry", m, m == 0 ? {31'h0, carry_a} : {31'h0, carry_b}, {31'h0, cy[m]});
        chk("an", m, m == 0 ? {30'h0, an_a} : {28'h0, an_b}, {28'h0, ean[m]});
        chk("seg7", m, m == 0 ? {25'h0, seg_a} : {25'h0, seg_b}, {25'h0, eseg[m]});
      end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [3:0] scan_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] scan_seg [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
    int n;
    #2 rst = 0;
    #1 chk_on = 1;
    cycles(2);
    chk("rst_count", 0, {24'h0, count_a}, 32'h00);
    chk("rst_carry", 0, {31'h0, carry_a}, 32'h0);
    chk("rst_seg7", 0, {25'h0, seg_a}, 32'b0000001);
    chk("rst_an", 0, {30'h0, an_a}, 32'b10);
    chk("rst_an", 1, {28'h0, an_b}, 32'b1110);
    rst = 1; enable = 1; up_down = 1;
    cycles(10);
    chk("first_tick", 0, {24'h0, count_a}, 32'h01);
    cycles(90);
    chk("bcd_digit_carry", 0, {24'h0, count_a}, 32'h10);
    chk("hex_count", 1, {16'h0, count_b}, 32'h0021);
    load = 1; load_value = 16'h0099;
    cycles(1);
    load = 0;
    cycles(1);
    n = 0;
    while (!carry_a && n < 30) begin cycles(1); n++; end
    chk("wrap_up_carry", 0, {31'h0, carry_a}, 32'h1);
    chk("wrap_up_count", 0, {24'h0, count_a}, 32'h00);
    up_down = 0;
    cycles(1);
    n = 0;
    while (!carry_a && n < 30) begin cycles(1); n++; end
    chk("borrow_carry", 0, {31'h0, carry_a}, 32'h1);
    chk("borrow_count", 0, {24'h0, count_a}, 32'h99);
    enable = 0; load = 1; load_value = 16'h003C;
    cycles(1);
    load = 0;
    chk("bcd_clamp", 0, {24'h0, count_a}, 32'h39);
    chk("hex_no_clamp", 1, {16'h0, count_b}, 32'h003C);
    cycles(1);
    n = 0;
    while (an_b != 4'b1110 && n < 20) begin cycles(1); n++; end
    chk("hex_c_an", 1, {28'h0, an_b}, 32'b1110);
    chk("hex_c_seg", 1, {25'h0, seg_b}, 32'b0110001);
    load = 1; load_value = 16'h1234;
    cycles(1);
    load = 0;
    n = 0;
    while (an_b != 4'b0111 && n < 20) begin cycles(1); n++; end
    while (an_b != 4'b1110 && n < 40) begin cycles(1); n++; end
    for (int k = 0; k < 4; k++) begin
      chk("scan_an", 1, {28'h0, an_b}, {28'h0, scan_an[k]});
      chk("scan_seg", 1, {25'h0, seg_b}, {25'h0, scan_seg[k]});
      cycles(3);
    end
    enable = 1; up_down = 1;
    cycles(25);
    #3 rst = 0;
    cycles(1);
    chk("midrst_count", 0, {24'h0, count_a}, 32'h00);
    chk("midrst_carry", 0, {31'h0, carry_a}, 32'h0);
    chk("midrst_an", 0, {30'h0, an_a}, 32'b10);
    chk("midrst_seg", 0, {25'h0, seg_a}, 32'b0000001);
    rst = 1;
    cycles(55);
    chk("pre_hold_count", 0, {24'h0, count_a}, 32'h05);
    enable = 0;
    cycles(40);
    chk("hold_count", 0, {24'h0, count_a}, 32'h05);
    enable = 1;
    cycles(4);
    chk("phase_kept_before", 0, {24'h0, count_a}, 32'h05);
    cycles(1);
    chk("phase_kept_tick", 0, {24'h0, count_a}, 32'h06);
    for (int c = 0; c < 3000; c++) begin
      enable = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) up_down = ~up_down;
      load = $urandom_range(0, 59) == 0;
      case ($urandom_range(0, 3))
        0: load_value = 16'hFFFF;
        1: load_value = 16'h0000;
        2: load_value = 16'h9999 - 16'($urandom_range(0, 2));
        default: load_value = 16'($urandom);
      endcase
      cycles(1);
    end
    load = 0;
    cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
